barrel_shifter_pipe: RTL and testbench
======================================

# barrel_shifter_pipe

Parametrised, pipelined barrel shifter with a valid/ready stream interface. Supports rotate, logical and arithmetic shifts in either direction on a W-bit operand. One pipeline stage per shift-amount bit, full-rate throughput and per-stage backpressure. Sits between stream producers and consumers wherever a registered, variable shift is needed at clock rate.

## Interface
- W, default 8: operand width; must be a power of two, ≥ 2.
- S, default log2(W) (derived, not overridable): stage count and shift-amount width.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  W  operand.
- in_amt  input  S  shift amount, 0..W-1.
- in_dir  input  1  0 = left, 1 = right.
- in_mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (treated as rotate).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  W  shifted result.

## Operation
- Beat accepted when in_valid && in_ready. in_data, in_amt, in_dir and in_mode are captured together.
- Stage k (k = 0..S-1) applies a shift of 2^k when amt bit k is set, otherwise passes through. amt, dir and mode travel with the data.
- Rotate: bits leaving one end re-enter the other end.
- Logical: vacated bits are 0.
- Arithmetic right: vacated bits equal the operand's original bit W-1. Arithmetic left is identical to logical left.
- amt = 0 returns in_data unchanged in every mode.
- Each stage holds a valid bit. Stage k advances when stage k+1 (or the output, for the last stage) is empty or advancing in the same cycle. Bubbles collapse.
- in_ready = !reset && (stage 0 empty || stage 0 advancing). This is combinational from out_ready through the stage valids.
- out_valid = valid bit of stage S-1. out_data is that stage's register.
- At most S beats are in flight. Beat order is preserved.
- Accept and emit in the same cycle are allowed when the pipe is full and out_ready = 1.

## Timing
- Reset: all stage valid bits = 0, all data/amt/dir/mode registers = 0. Hence out_valid = 0, out_data = 0, and in_ready = 0 while reset is high.
- Reset mid-operation drops every in-flight beat. The first accept is possible in the first cycle after reset falls.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S-1, i.e. S cycles accept-to-output with no stall (3 cycles for W = 8).
- Throughput: one beat per cycle while out_ready = 1.
- While out_valid && !out_ready: out_data and out_valid hold stable. Upstream stages keep filling empty slots; in_ready falls only when all S stages are valid.
- in_data, in_amt, in_dir and in_mode are ignored when in_valid = 0 or in_ready = 0.

## Configuration
- BARREL_SHIFTER_PIPE_ARITH_EN defined: mode 10 with dir = 1 performs an arithmetic right shift (sign fill).
- Not defined: mode 10 behaves exactly as mode 01 (logical), no sign fill logic is built, and the sign bit is not carried through the stages.

## Test plan
- W=8, out_ready=1, beat 0x96, amt 3, dir 0, mode 00 -> out_data 0xB4 exactly 3 cycles after accept. Same beat with dir 1, amt 1 -> 0x4B.
- W=8, 0x96, amt 2, dir 1, mode 10 -> 0xE5 with BARREL_SHIFTER_PIPE_ARITH_EN defined, 0x25 without. Mode 01, dir 0, amt 3 -> 0xB0. Any mode with amt 0 -> 0x96.
- Back-to-back stream of 8 beats, in_valid=1 and out_ready=1 throughout -> in_ready stays 1, results emerge on 8 consecutive cycles in order.
- Hold out_ready=0 and offer beats continuously -> exactly 3 accepted, in_ready=0, out_data stable. Raise out_ready for one cycle -> one result out and one new beat accepted the same cycle.
- Assert reset for one cycle with 3 beats in flight -> out_valid=0 and out_data=0 next cycle, no stale beat ever emerges, in_ready=1 the cycle after reset falls.
- W=32 instance: 0x8000_0001, amt 31, dir 0, mode 00 -> 0xC000_0000 after 5 cycles. Randomised beats checked against a reference model.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, valid/ready stream.
// Define BARREL_SHIFTER_PIPE_ARITH_EN to build the arithmetic right shift (sign fill) for mode 10.

module barrel_shifter_pipe #(
  parameter  int W = 8,
  localparam int S = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [S-1:0] in_amt,
  input  logic         in_dir,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [S-1:0] valid_q;
  logic [S-1:0] adv;
  logic [S-1:0] load;
  logic [W-1:0] data_q   [S];
  logic [S-1:0] amt_q    [S];
  logic         dir_q    [S];
  logic [1:0]   mode_q   [S];
  logic [W-1:0] src_data [S];
  logic [S-1:0] src_amt  [S];
  logic         src_dir  [S];
  logic [1:0]   src_mode [S];
  logic [W-1:0] shifted  [S];
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
  logic         sign_q   [S];
  logic         src_sign [S];
`endif

  // Walk from the output back to stage 0: a stage may move on when the slot after it has room.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = S - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] && room;
      room   = !valid_q[k] || adv[k];
    end
    in_ready = !reset && room;
    load     = adv << 1;
    load[0]  = in_valid && in_ready;
  end

  always_comb begin
    int p;
    int sh;
    for (int k = 0; k < S; k++) begin
      p  = (k == 0) ? 0 : k - 1;
      sh = 1 << k;
      src_data[k] = (k == 0) ? in_data : data_q[p];
      src_amt[k]  = (k == 0) ? in_amt  : amt_q[p];
      src_dir[k]  = (k == 0) ? in_dir  : dir_q[p];
      src_mode[k] = (k == 0) ? in_mode : mode_q[p];
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
      src_sign[k] = (k == 0) ? in_data[W-1] : sign_q[p];
`endif
      shifted[k] = src_data[k];
      if (src_amt[k][k]) begin
        if (src_mode[k] == 2'b01 || src_mode[k] == 2'b10)
          shifted[k] = src_dir[k] ? (src_data[k] >> sh) : (src_data[k] << sh);
        else
          shifted[k] = src_dir[k] ? ((src_data[k] >> sh) | (src_data[k] << (W - sh)))
                                  : ((src_data[k] << sh) | (src_data[k] >> (W - sh)));
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
        // The sign rides along from stage 0 so every stage fills with the operand's original MSB.
        if (src_mode[k] == 2'b10 && src_dir[k] && src_sign[k])
          shifted[k] = shifted[k] | ~({W{1'b1}} >> sh);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < S; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        dir_q[k]  <= 1'b0;
        mode_q[k] <= '0;
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
        sign_q[k] <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= shifted[k];
          amt_q[k]   <= src_amt[k];
          dir_q[k]   <= src_dir[k];
          mode_q[k]  <= src_mode[k];
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
          sign_q[k]  <= src_sign[k];
`endif
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: W=8 and W=32 instances, directed cases plus random traffic
// checked against a whole-amount reference model and an in-order scoreboard.

module tb_barrel_shifter_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_r  [2];
  logic        out_ready_r [2];
  logic [31:0] in_data_r   [2];
  logic [4:0]  in_amt_r    [2];
  logic        in_dir_r    [2];
  logic [1:0]  in_mode_r   [2];
  wire  [1:0]  in_ready_w;
  wire  [1:0]  out_valid_w;
  wire  [7:0]  out_data8;
  wire  [31:0] out_data32;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.W(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data_r[0][7:0]), .in_amt(in_amt_r[0][2:0]),
    .in_dir(in_dir_r[0]), .in_mode(in_mode_r[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]), .out_data(out_data8)
  );

  barrel_shifter_pipe #(.W(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data_r[1]), .in_amt(in_amt_r[1]),
    .in_dir(in_dir_r[1]), .in_mode(in_mode_r[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]), .out_data(out_data32)
  );

  function automatic int width_of(int sel);
    return (sel == 1) ? 32 : 8;
  endfunction

  function automatic int stages_of(int sel);
    return (sel == 1) ? 5 : 3;
  endfunction

  function automatic logic [31:0] out_data_of(int sel);
    return (sel == 1) ? out_data32 : {24'h0, out_data8};
  endfunction

  // Whole-amount shift computed directly from the operation rules.
  function automatic logic [31:0] ref_shift(int w, logic [31:0] d, logic [4:0] amt_raw,
                                            logic dir, logic [1:0] mode);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] r;
    int n;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    n    = int'(amt_raw) % w;
    if (n == 0) begin
      r = x;
    end else if (mode == 2'b01 || mode == 2'b10) begin
      r = dir ? (x >> n) : (x << n);
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
      if (mode == 2'b10 && dir && x[w-1]) r = r | (mask & ~(mask >> n));
`endif
    end else begin
      r = dir ? ((x >> n) | (x << (w - n))) : ((x << n) | (x >> (w - n)));
    end
    r = r & mask;
    return r[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic ready);
    in_valid_r[sel]  = valid;
    out_ready_r[sel] = ready;
    in_data_r[sel]   = $urandom;
    in_amt_r[sel]    = 5'($urandom);
    in_dir_r[sel]    = 1'($urandom);
    in_mode_r[sel]   = 2'($urandom);
  endtask

  // Scoreboard per instance: expected results queued on accept, popped on emit; stalled output must hold.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [31:0] expq[$];
    logic        stalled = 1'b0;
    logic [31:0] held    = '0;
    always @(negedge clk) begin
      if (reset) begin
        expq.delete();
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput($sformatf("hold_valid_w%0d", width_of(g)), out_valid_w[g], 1'b1);
          checkOutput($sformatf("hold_data_w%0d", width_of(g)), out_data_of(g), held);
        end
        if (out_valid_w[g] && out_ready_r[g]) begin
          if (expq.size() == 0)
            checkOutput($sformatf("spurious_beat_w%0d", width_of(g)), out_valid_w[g], 1'b0);
          else
            checkOutput($sformatf("data_w%0d", width_of(g)), out_data_of(g), expq.pop_front());
        end
        if (in_valid_r[g] && in_ready_w[g])
          expq.push_back(ref_shift(width_of(g), in_data_r[g], in_amt_r[g], in_dir_r[g], in_mode_r[g]));
        stalled = out_valid_w[g] && !out_ready_r[g];
        held    = out_data_of(g);
      end
    end
  end

  // One beat into an empty pipe: checks acceptance, accept-to-output latency and the result.
  task automatic directed(input int sel, input logic [31:0] d, input logic [4:0] amt, input logic dir,
                          input logic [1:0] mode, input logic [31:0] exp, input string tag);
    int lat;
    in_valid_r[sel]  = 1'b1;
    out_ready_r[sel] = 1'b1;
    in_data_r[sel]   = d;
    in_amt_r[sel]    = amt;
    in_dir_r[sel]    = dir;
    in_mode_r[sel]   = mode;
    @(negedge clk);
    checkOutput({tag, "_ready"}, in_ready_w[sel], 1'b1);
    @(posedge clk); #1;
    in_valid_r[sel] = 1'b0;
    lat = 1;
    while (!out_valid_w[sel] && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, stages_of(sel));
    checkOutput({tag, "_data"}, out_data_of(sel), exp);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [15:0] ov;
    logic [15:0] exp_ov;
    int acc;
    int drain;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      applyStimulus(g, 1'b0, 1'b1);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("rst_in_ready_w%0d", width_of(g)), in_ready_w[g], 1'b0);
      checkOutput($sformatf("rst_out_valid_w%0d", width_of(g)), out_valid_w[g], 1'b0);
      checkOutput($sformatf("rst_out_data_w%0d", width_of(g)), out_data_of(g), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset_w8", in_ready_w[0], 1'b1);
    @(posedge clk); #1;

    $display("[TB] directed cases");
    directed(0, 32'h96, 5'd3, 1'b0, 2'b00, 32'hB4, "rotl3");
    directed(0, 32'h96, 5'd1, 1'b1, 2'b00, 32'h4B, "rotr1");
`ifdef BARREL_SHIFTER_PIPE_ARITH_EN
    directed(0, 32'h96, 5'd2, 1'b1, 2'b10, 32'hE5, "asr2");
`else
    directed(0, 32'h96, 5'd2, 1'b1, 2'b10, 32'h25, "asr2_as_lsr");
`endif
    directed(0, 32'h96, 5'd3, 1'b0, 2'b01, 32'hB0, "lsl3");
    directed(0, 32'h96, 5'd3, 1'b0, 2'b11, 32'hB4, "mode11_rotl3");
    for (int m = 0; m < 4; m++) begin
      directed(0, 32'h96, 5'd0, 1'(m), 2'(m), 32'h96, $sformatf("amt0_mode%0d", m));
    end
    directed(1, 32'h8000_0001, 5'd31, 1'b0, 2'b00, 32'hC000_0000, "w32_rotl31");
    @(posedge clk); #1;

    $display("[TB] back-to-back stream");
    ov = '0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, i < 8, 1'b1);
      @(negedge clk);
      if (i < 8) checkOutput($sformatf("b2b_ready%0d", i), in_ready_w[0], 1'b1);
      ov[i] = out_valid_w[0];
      @(posedge clk); #1;
    end
    exp_ov = 16'hFF << stages_of(0);
    checkOutput("b2b_out_valid_pattern", {16'h0, ov}, {16'h0, exp_ov});

    $display("[TB] stall and release");
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1'b1, 1'b0);
      @(negedge clk);
      if (in_valid_r[0] && in_ready_w[0]) acc++;
      @(posedge clk); #1;
    end
    checkOutput("stall_accepted", acc, stages_of(0));
    @(negedge clk);
    checkOutput("stall_in_ready", in_ready_w[0], 1'b0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("release_in_ready", in_ready_w[0], 1'b1);
    checkOutput("release_out_valid", out_valid_w[0], 1'b1);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("refull_in_ready", in_ready_w[0], 1'b0);
    checkOutput("refull_out_valid", out_valid_w[0], 1'b1);
    @(posedge clk); #1;

    $display("[TB] reset with beats in flight");
    in_valid_r[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready_w[0], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready_r[0] = 1'b1;
    @(negedge clk);
    checkOutput("postrst_out_valid", out_valid_w[0], 1'b0);
    checkOutput("postrst_out_data", out_data_of(0), 32'h0);
    checkOutput("postrst_in_ready", in_ready_w[0], 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int g = 0; g < 2; g++) begin
        applyStimulus(g, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      applyStimulus(g, 1'b0, 1'b1);
    end
    drain = 0;
    while ((g_mon[0].expq.size() != 0 || g_mon[1].expq.size() != 0) && drain < 50) begin
      @(posedge clk); #1;
      drain++;
    end
    @(negedge clk);
    checkOutput("drain_w8", g_mon[0].expq.size(), 0);
    checkOutput("drain_w32", g_mon[1].expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
